// File: rtl/axis_cplx_ref_mult.sv
// AXI-Stream complex multiplier: each input sample times the matching entry of a BRAM-held
// reference sequence (optional conjugate). Define CMULT_SAT_EN for saturating narrowing and sat_flag.
module axis_cplx_ref_mult #(
   parameter int DATA_W    = 16,
   parameter int REF_W     = 16,
   parameter int OUT_W     = 32,
   parameter int OUT_SHIFT = 0,
   parameter int SEQ_LEN   = 1024,
   parameter int ADDR_W    = 10
) (
   input  logic                  m00_axis_aclk,
   input  logic                  m00_axis_areset,
   input  logic [2*DATA_W-1:0]   S00_AXIS_tdata,
   input  logic                  S00_AXIS_tvalid,
   output logic                  S00_AXIS_tready,
   input  logic                  S00_AXIS_tlast,
   output logic [2*OUT_W-1:0]    M00_AXIS_tdata,
   output logic                  M00_AXIS_tvalid,
   input  logic                  M00_AXIS_tready,
   output logic                  M00_AXIS_tlast,
   output logic [ADDR_W-1:0]     bram_addr,
   output logic                  bram_en,
   input  logic [2*REF_W-1:0]    bram_dout,
   input  logic                  conj_en
`ifdef CMULT_SAT_EN
   ,
   output logic                  sat_flag
`endif
);

   localparam int PW = DATA_W + REF_W;
   localparam int FW = DATA_W + REF_W + 1;

   logic w_adv;
   logic w_accept;
   logic w_idx_last;
   logic w_mode_cur;

   logic [ADDR_W-1:0] r_idx;
   logic              r_mode;

   logic                     r1_valid;
   logic signed [DATA_W-1:0] r1_xi;
   logic signed [DATA_W-1:0] r1_xq;
   logic                     r1_last;
   logic                     r1_mode;

   logic                 r2_valid;
   logic signed [PW-1:0] r2_p_ii;
   logic signed [PW-1:0] r2_p_qq;
   logic signed [PW-1:0] r2_p_iq;
   logic signed [PW-1:0] r2_p_qi;
   logic                 r2_last;
   logic                 r2_mode;

   logic             r3_valid;
   logic [OUT_W-1:0] r3_i;
   logic [OUT_W-1:0] r3_q;
   logic             r3_last;

   logic signed [REF_W-1:0] w_ri;
   logic signed [REF_W-1:0] w_rq;
   logic signed [PW-1:0]    w_xi_e;
   logic signed [PW-1:0]    w_xq_e;
   logic signed [PW-1:0]    w_ri_e;
   logic signed [PW-1:0]    w_rq_e;

   logic signed [FW-1:0] w_ii_e;
   logic signed [FW-1:0] w_qq_e;
   logic signed [FW-1:0] w_iq_e;
   logic signed [FW-1:0] w_qi_e;
   logic signed [FW-1:0] w_sum_i;
   logic signed [FW-1:0] w_sum_q;
   logic signed [FW-1:0] w_sh_i;
   logic signed [FW-1:0] w_sh_q;
   logic [OUT_W-1:0]     w_o_i;
   logic [OUT_W-1:0]     w_o_q;

   // A single enable for every stage keeps the BRAM output aligned with stage 1 across stalls.
   assign w_adv           = M00_AXIS_tready | ~r3_valid;
   assign w_accept        = S00_AXIS_tvalid & w_adv;
   assign S00_AXIS_tready = w_adv;
   assign bram_en         = w_adv;
   assign bram_addr       = r_idx;

   assign w_idx_last = (r_idx == ADDR_W'(SEQ_LEN - 1));
   assign w_mode_cur = (r_idx == '0) ? conj_en : r_mode;

   always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
      if (m00_axis_areset) begin
         r_idx  <= '0;
         r_mode <= 1'b0;
      end else if (w_accept) begin
         r_mode <= w_mode_cur;
         if (S00_AXIS_tlast || w_idx_last) begin
            r_idx <= '0;
         end else begin
            r_idx <= r_idx + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
      if (m00_axis_areset) begin
         r1_valid <= 1'b0;
         r1_xi    <= '0;
         r1_xq    <= '0;
         r1_last  <= 1'b0;
         r1_mode  <= 1'b0;
      end else if (w_adv) begin
         r1_valid <= w_accept;
         if (w_accept) begin
            r1_xi   <= S00_AXIS_tdata[DATA_W-1:0];
            r1_xq   <= S00_AXIS_tdata[2*DATA_W-1:DATA_W];
            r1_last <= w_idx_last | S00_AXIS_tlast;
            r1_mode <= w_mode_cur;
         end
      end
   end

   assign w_ri   = bram_dout[REF_W-1:0];
   assign w_rq   = bram_dout[2*REF_W-1:REF_W];
   assign w_xi_e = PW'(r1_xi);
   assign w_xq_e = PW'(r1_xq);
   assign w_ri_e = PW'(w_ri);
   assign w_rq_e = PW'(w_rq);

   always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
      if (m00_axis_areset) begin
         r2_valid <= 1'b0;
         r2_p_ii  <= '0;
         r2_p_qq  <= '0;
         r2_p_iq  <= '0;
         r2_p_qi  <= '0;
         r2_last  <= 1'b0;
         r2_mode  <= 1'b0;
      end else if (w_adv) begin
         r2_valid <= r1_valid;
         if (r1_valid) begin
            r2_p_ii <= w_xi_e * w_ri_e;
            r2_p_qq <= w_xq_e * w_rq_e;
            r2_p_iq <= w_xi_e * w_rq_e;
            r2_p_qi <= w_xq_e * w_ri_e;
            r2_last <= r1_last;
            r2_mode <= r1_mode;
         end
      end
   end

   assign w_ii_e = FW'(r2_p_ii);
   assign w_qq_e = FW'(r2_p_qq);
   assign w_iq_e = FW'(r2_p_iq);
   assign w_qi_e = FW'(r2_p_qi);

   always_comb begin
      w_sum_i = '0;
      w_sum_q = '0;
      if (r2_mode) begin
         w_sum_i = w_ii_e + w_qq_e;
         w_sum_q = w_qi_e - w_iq_e;
      end else begin
         w_sum_i = w_ii_e - w_qq_e;
         w_sum_q = w_iq_e + w_qi_e;
      end
   end

   assign w_sh_i = w_sum_i >>> OUT_SHIFT;
   assign w_sh_q = w_sum_q >>> OUT_SHIFT;

`ifdef CMULT_SAT_EN
   // Compare in a width wider than both FW and OUT_W so the bounds are exact either way round.
   localparam int XW = ((FW > OUT_W) ? FW : OUT_W) + 1;
   localparam logic signed [XW-1:0] SAT_MAX = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [XW-1:0] SAT_MIN = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [XW-1:0] w_x_i;
   logic signed [XW-1:0] w_x_q;
   logic                 w_sat_i;
   logic                 w_sat_q;
   logic                 r_sat;

   assign w_x_i = XW'(w_sh_i);
   assign w_x_q = XW'(w_sh_q);

   always_comb begin
      w_o_i   = w_x_i[OUT_W-1:0];
      w_sat_i = 1'b0;
      if (w_x_i > SAT_MAX) begin
         w_o_i   = SAT_MAX[OUT_W-1:0];
         w_sat_i = 1'b1;
      end else if (w_x_i < SAT_MIN) begin
         w_o_i   = SAT_MIN[OUT_W-1:0];
         w_sat_i = 1'b1;
      end
   end

   always_comb begin
      w_o_q   = w_x_q[OUT_W-1:0];
      w_sat_q = 1'b0;
      if (w_x_q > SAT_MAX) begin
         w_o_q   = SAT_MAX[OUT_W-1:0];
         w_sat_q = 1'b1;
      end else if (w_x_q < SAT_MIN) begin
         w_o_q   = SAT_MIN[OUT_W-1:0];
         w_sat_q = 1'b1;
      end
   end

   always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
      if (m00_axis_areset) begin
         r_sat <= 1'b0;
      end else if (w_adv && r2_valid && (w_sat_i || w_sat_q)) begin
         r_sat <= 1'b1;
      end
   end

   assign sat_flag = r_sat;
`else
   assign w_o_i = OUT_W'(w_sh_i);
   assign w_o_q = OUT_W'(w_sh_q);
`endif

   always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
      if (m00_axis_areset) begin
         r3_valid <= 1'b0;
         r3_i     <= '0;
         r3_q     <= '0;
         r3_last  <= 1'b0;
      end else if (w_adv) begin
         r3_valid <= r2_valid;
         if (r2_valid) begin
            r3_i    <= w_o_i;
            r3_q    <= w_o_q;
            r3_last <= r2_last;
         end
      end
   end

   assign M00_AXIS_tvalid = r3_valid;
   assign M00_AXIS_tdata  = {r3_q, r3_i};
   assign M00_AXIS_tlast  = r3_last;

endmodule

// File: tb/tb_axis_cplx_ref_mult.sv
// Scoreboard bench for axis_cplx_ref_mult (SEQ_LEN=8); driver pushes expectations, monitor pops.
module tb_axis_cplx_ref_mult;

   localparam int DW = 16;
   localparam int RW = 16;
   localparam int OW = 32;
   localparam int SL = 8;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2*DW-1:0] s_tdata;
   logic            s_tvalid;
   logic            s_tready;
   logic            s_tlast;
   logic [2*OW-1:0] m_tdata;
   logic            m_tvalid;
   logic            m_tready;
   logic            m_tlast;
   logic [AW-1:0]   bram_addr;
   logic            bram_en;
   logic [2*RW-1:0] bram_dout = '0;
   logic            conj_en;
`ifdef CMULT_SAT_EN
   logic            sat_flag;
`endif

   axis_cplx_ref_mult #(
      .DATA_W(DW), .REF_W(RW), .OUT_W(OW), .OUT_SHIFT(0), .SEQ_LEN(SL), .ADDR_W(AW)
   ) dut (
      .m00_axis_aclk(clk),
      .m00_axis_areset(rst),
      .S00_AXIS_tdata(s_tdata),
      .S00_AXIS_tvalid(s_tvalid),
      .S00_AXIS_tready(s_tready),
      .S00_AXIS_tlast(s_tlast),
      .M00_AXIS_tdata(m_tdata),
      .M00_AXIS_tvalid(m_tvalid),
      .M00_AXIS_tready(m_tready),
      .M00_AXIS_tlast(m_tlast),
      .bram_addr(bram_addr),
      .bram_en(bram_en),
      .bram_dout(bram_dout),
      .conj_en(conj_en)
`ifdef CMULT_SAT_EN
      ,
      .sat_flag(sat_flag)
`endif
   );

   logic [2*RW-1:0] ref_mem [SL];
   always @(posedge clk) if (bram_en) bram_dout <= ref_mem[bram_addr];

   typedef struct {
      logic [31:0] i;
      logic [31:0] q;
      logic        last;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   midx   = 0;
   logic mmode  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic exp_t model(input int xi, input int xq, input int ri, input int rq, input logic md);
      exp_t   e;
      longint ii, qq, iq, qi, si, sq;
      ii = longint'(xi) * ri;
      qq = longint'(xq) * rq;
      iq = longint'(xi) * rq;
      qi = longint'(xq) * ri;
      si = md ? ii + qq : ii - qq;
      sq = md ? qi - iq : iq + qi;
`ifdef CMULT_SAT_EN
      if (si > 64'sd2147483647) si = 64'sd2147483647;
      if (si < -64'sd2147483648) si = -64'sd2147483648;
      if (sq > 64'sd2147483647) sq = 64'sd2147483647;
      if (sq < -64'sd2147483648) sq = -64'sd2147483648;
`endif
      e.i    = si[31:0];
      e.q    = sq[31:0];
      e.last = 1'b0;
      return e;
   endfunction

   // Issue one sample; expected value is hand-supplied (use_hand) or from the model.
   task automatic send(input int xi, input int xq, input logic last,
                       input logic use_hand, input int hi, input int hq);
      exp_t e;
      int   ri, rq, t;
      s_tdata  = {xq[15:0], xi[15:0]};
      s_tlast  = last;
      s_tvalid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (s_tready) break;
         t++;
         if (t > 200) begin
            chk("accept_timeout", 64'(t), 64'd0);
            s_tvalid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      chk("bram_addr", 64'(bram_addr), 64'(midx));
      if (midx == 0) mmode = conj_en;
      ri = int'($signed(ref_mem[midx][15:0]));
      rq = int'($signed(ref_mem[midx][31:16]));
      if (use_hand) begin
         e.i = hi;
         e.q = hq;
      end else begin
         e = model(xi, xq, ri, rq, mmode);
      end
      e.last = (midx == SL - 1) || last;
      sb.push_back(e);
      midx = (last || midx == SL - 1) ? 0 : midx + 1;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      for (int t = 0; t < 500 && sb.size() != 0; t++) begin @(posedge clk); #1; end
      chk("drain", 64'(sb.size()), 64'd0);
   endtask

   function automatic int rx_i(input int k); return 1000 * k - 6987; endfunction
   function automatic int rx_q(input int k); return 3000 - 700 * k; endfunction

   // Output monitor: scoreboard pop on handshake, hold checks during stalls.
   logic        prev_stall = 1'b0;
   logic [63:0] held_data  = '0;
   logic        held_last  = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (prev_stall && m_tvalid) begin
            chk("stall_data", m_tdata, held_data);
            chk("stall_last", 64'(m_tlast), 64'(held_last));
         end
         if (m_tvalid && !m_tready) begin
            chk("stall_s_tready", 64'(s_tready), 64'd0);
            chk("stall_bram_en", 64'(bram_en), 64'd0);
         end
         if (m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
               e = sb.pop_front();
               chk("out_i", 64'(m_tdata[31:0]), 64'(e.i));
               chk("out_q", 64'(m_tdata[63:32]), 64'(e.q));
               chk("out_last", 64'(m_tlast), 64'(e.last));
            end
         end
         prev_stall = m_tvalid && !m_tready;
         held_data  = m_tdata;
         held_last  = m_tlast;
      end
   end

   logic rnd_en  = 1'b0;
   int   low_cnt = 0;
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (!rnd_en) m_tready = 1'b1;
         else if (low_cnt > 0) begin
            m_tready = 1'b0;
            low_cnt--;
         end else m_tready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < SL; k++) ref_mem[k] = {16'(2 - k), 16'(k + 1)};
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tlast  = 1'b0;
      conj_en  = 1'b0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_m_tdata", m_tdata, 64'd0);
      chk("rst_m_tlast", 64'(m_tlast), 64'd0);
      chk("rst_bram_addr", 64'(bram_addr), 64'd0);
`ifdef CMULT_SAT_EN
      chk("rst_sat_flag", 64'(sat_flag), 64'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("s_tready_after_reset", 64'(s_tready), 64'd1);
      @(posedge clk); #1;

      // x=(3,4) r=(1,2) normal; conj_en raised mid-sequence must not take effect (r=(2,1)).
      send(3, 4, 1'b0, 1'b1, -5, 10);
      conj_en = 1'b1;
      send(3, 4, 1'b0, 1'b1, 2, 11);
      for (int k = 2; k < SL; k++) send(rx_i(k), rx_q(k), 1'b0, 1'b0, 0, 0);

      // New sequence latches conjugate mode; dropping conj_en mid-sequence keeps it.
      send(3, 4, 1'b0, 1'b1, 11, -2);
      conj_en = 1'b0;
      for (int k = 1; k < SL; k++) send(rx_i(k), rx_q(k), 1'b0, 1'b0, 0, 0);
      idle(4);

      for (int k = 0; k < 20; k++) send(rx_i(k), rx_q(k), 1'b0, 1'b0, 0, 0);
      // Finish the sequence with tlast coinciding with idx 7.
      for (int k = 20; k < 24; k++) send(rx_i(k), rx_q(k), (k == 23), 1'b0, 0, 0);
      idle(3);
      for (int k = 0; k < 12; k++) send(rx_i(k), rx_q(k), (k == 3), 1'b0, 0, 0);
      idle(3);
      drain();

      conj_en = 1'b1;
      rnd_en  = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (k == 10) low_cnt = 5;
         send(rx_i(k), rx_q(k), 1'b0, 1'b0, 0, 0);
         if (k % 7 == 3) idle(1);
      end
      idle(2);
      drain();
      rnd_en  = 1'b0;
      conj_en = 1'b0;
      idle(2);

      // Reset with samples in flight; they must be discarded.
      for (int k = 0; k < 5; k++) send(rx_i(k), rx_q(k), 1'b0, 1'b0, 0, 0);
      rst = 1'b1;
      s_tvalid = 1'b0;
      sb.delete();
      midx  = 0;
      mmode = 1'b0;
      #1;
      chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("mid_rst_m_tdata", m_tdata, 64'd0);
      chk("mid_rst_m_tlast", 64'(m_tlast), 64'd0);
      chk("mid_rst_bram_addr", 64'(bram_addr), 64'd0);
      ref_mem[0] = {16'h8000, 16'h8000};
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;

`ifdef CMULT_SAT_EN
      send(-32768, -32768, 1'b0, 1'b1, 0, 32'h7FFFFFFF);
`else
      send(-32768, -32768, 1'b0, 1'b1, 0, 32'h80000000);
`endif
      s_tvalid = 1'b0;
      @(negedge clk);
      chk("latency_edge_n", 64'(m_tvalid), 64'd0);
      @(negedge clk);
      chk("latency_edge_n1", 64'(m_tvalid), 64'd0);
      @(negedge clk);
      chk("latency_edge_n2", 64'(m_tvalid), 64'd1);
`ifdef CMULT_SAT_EN
      chk("sat_flag", 64'(sat_flag), 64'd1);
`endif
      idle(4);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
